// File: rtl/fetch_sequencer.sv
// fetch_sequencer: FETCH / DECODE / EXEC / HALT instruction sequencer.
// It waits on a memory-ready handshake and drives the PC and the latched
// instruction word. The datapath can hold DECODE and EXEC with stall.
// EXEC loads either the branch target or PC+PC_STEP into the PC.
// An op_code equal to HALT_OPCODE parks the sequencer in HALT until reset.
// Optional feature: define FETCH_SEQ_TIMEOUT_EN to enable a fetch-wait
// timeout. When it expires, the sequencer raises a sticky fault and halts.
module fetch_sequencer #(
    parameter int           ADDR_W         = 16,
    parameter int           INSTR_W        = 32,
    parameter int           RESET_PC       = 0,
    parameter int           PC_STEP        = 1,
    parameter logic [3:0]   HALT_OPCODE    = 4'hF,
    parameter int           TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ready,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [1:0]         current_state,
    output logic               exec_valid,
    output logic               halted,
    output logic               fault
);

    localparam logic [1:0] S_FETCH  = 2'b00;
    localparam logic [1:0] S_DECODE = 2'b01;
    localparam logic [1:0] S_EXEC   = 2'b10;
    localparam logic [1:0] S_HALT   = 2'b11;

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);

    logic [1:0]         state;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [3:0]         op_code;
    logic               timeout_hit;

    // op_code sits in the same field the existing decode uses ([27:24] at 32 bits)
    assign op_code = instr_q[INSTR_W-5 -: 4];

`ifdef FETCH_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q;

    // The edge that would bring the count to TIMEOUT_CYCLES is the one that faults
    assign timeout_hit = (state == S_FETCH) && !mem_ready && (wait_cnt == CNT_LAST);

    // Count consecutive un-ready FETCH cycles; any other state or a ready beat clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (state != S_FETCH || mem_ready) begin
                wait_cnt <= '0;
            end else if (!timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout_hit) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault = fault_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
    assign fault          = 1'b0;
`endif

    // Sequencer state, PC and instruction latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc_q    <= PC_INIT;
            instr_q <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (timeout_hit) begin
                        state <= S_HALT;
                    end else if (mem_ready) begin
                        instr_q <= mem_rdata;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!stall) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // stall wins; branch_taken is only looked at on the releasing cycle
                    if (!stall) begin
                        if (op_code == HALT_OPCODE) begin
                            state <= S_HALT;
                        end else begin
                            pc_q  <= branch_taken ? branch_target : pc_q + PC_INC;
                            state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    assign mem_req       = (state == S_FETCH);
    assign exec_valid    = (state == S_EXEC);
    assign halted        = (state == S_HALT);
    assign current_state = state;
    assign pc_out        = pc_q;
    assign instr_out     = instr_q;

endmodule
